onehot_step_sequencer: RTL



---
 rtl/onehot_step_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/onehot_step_sequencer.sv
// Step sequencer with a registered one-hot decode of the current step, run/hold control and wrap/err pulses.
// Latency: start -> one-hot on out after 1 clock; all outputs are registered.
module onehot_step_sequencer #(
  parameter int SEL_W     = 4,
  parameter int LAST_STEP = 2**SEL_W-1,
  parameter bit ONESHOT   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  input  logic                halt,
  input  logic                clr_step,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    step,
  output logic                busy,
  output logic                wrap,
  output logic                err
);

  localparam int N = 2**SEL_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LAST_STEP);
  localparam logic [N-1:0]     ONE  = N'(1);

  logic [1:0]       state, state_nx;
  logic [SEL_W-1:0] step_nx;
  logic             wrap_nx, err_nx;

  // Priority: start > clr_step > halt > advance; rst is applied in the register block.
  always_comb begin
    state_nx = state;
    step_nx  = step;
    wrap_nx  = 1'b0;
    err_nx   = 1'b0;
    if (start) begin
      state_nx = RUN;
      if (sel > LAST) begin
        step_nx = '0;
        err_nx  = 1'b1;
      end else begin
        step_nx = sel;
      end
    end else if (state != IDLE) begin
      if (clr_step) begin
        step_nx = '0;
        if (halt) state_nx = HOLD;
      end else if (halt) begin
        state_nx = HOLD;
      end else if (state == HOLD) begin
        // Leaving HOLD costs one clock; advancing resumes on the next en.
        state_nx = RUN;
      end else if (en) begin
        if (step == LAST) begin
          step_nx = '0;
          wrap_nx = 1'b1;
          if (ONESHOT) state_nx = IDLE;
        end else begin
          step_nx = step + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      out   <= '0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      out   <= (state_nx == IDLE) ? '0 : (ONE << step_nx);
      busy  <= (state_nx != IDLE);
      wrap  <= wrap_nx;
      err   <= err_nx;
    end
  end

endmodule
